// File: rtl/pipelined_data_memory_pkg.sv
// Shared types and helpers for the MEM-stage data memory: controller states,
// byte-lane count and the word-address range check.
package pipelined_data_memory_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    // Addresses at or beyond DEPTH are flagged rather than wrapped.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/data_memory_bank.sv
// DEPTH x DATA_W storage array: per-byte-lane synchronous write and one
// registered read port that only updates when a read is issued.
module data_memory_bank
    import pipelined_data_memory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata
);

    localparam int STRB_W = strb_width(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read register holds its value between reads so a stalled response stays stable.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pipelined_data_memory.sv
// MEM-stage data memory: post-reset clear sequence, byte-strobed writes and a
// one-cycle registered read with valid/ready backpressure.
module pipelined_data_memory
    import pipelined_data_memory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     outputf,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int STRB_W = strb_width(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;

    logic                ready_c;
    logic                accept;
    logic                in_range;
    logic                bank_we;
    logic                bank_re;
    logic [ADDR_W-1:0]   bank_addr;
    logic [DATA_W-1:0]   bank_wdata;
    logic [STRB_W-1:0]   bank_wstrb;
    logic [DATA_W-1:0]   bank_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        bank_we     = 1'b0;
        bank_re     = 1'b0;
        bank_addr   = address;
        bank_wdata  = wdata;
        bank_wstrb  = wstrb;

        in_range = addr_in_range(32'(address), DEPTH);
        ready_c  = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
        accept   = req_valid && ready_c;

        case (state_q)
            ST_INIT: begin
                bank_we    = 1'b1;
                bank_addr  = cnt_q;
                bank_wdata = '0;
                bank_wstrb = '1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            ST_RUN: begin
                // A new read overrides the retiring response, giving back-to-back beats.
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
                if (accept && req_we) begin
                    bank_we = in_range;
                end
                if (accept && !req_we) begin
                    bank_re     = in_range;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !in_range;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    data_memory_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .re    (bank_re),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .wstrb (bank_wstrb),
        .rdata (bank_rdata)
    );

    // Out-of-range reads and idle cycles present zero instead of stale bank contents.
    assign outputf   = (rsp_valid_q && !rsp_err_q) ? bank_rdata : '0;
    assign req_ready = ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Drives identical traffic into a DEPTH=256 and a DEPTH=200 instance and
// compares both against an array-based reference model of the memory.
module tb_pipelined_data_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rsp_ready;

    logic        req_ready_o [2];
    logic        rsp_valid_o [2];
    logic        rsp_err_o   [2];
    logic        init_done_o [2];
    logic [31:0] outputf_o   [2];

    always #5 clk = ~clk;

    pipelined_data_memory #(.DATA_W(32), .DEPTH(256), .ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_o[0]),
        .req_we(req_we), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready), .outputf(outputf_o[0]),
        .rsp_err(rsp_err_o[0]), .init_done(init_done_o[0])
    );

    pipelined_data_memory #(.DATA_W(32), .DEPTH(200), .ADDR_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_o[1]),
        .req_we(req_we), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready), .outputf(outputf_o[1]),
        .rsp_err(rsp_err_o[1]), .init_done(init_done_o[1])
    );

    // Reference model: plain word arrays plus the expected pending response.
    bit [31:0] mem   [2][256];
    int        depth [2] = '{256, 200};
    int        edges;
    bit        ev    [2];
    bit [31:0] ed    [2];
    bit        ee    [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input int d);
        return (edges >= depth[d]) && (!ev[d] || rsp_ready);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 256; w++) mem[d][w] = '0;
            ev[d] = 1'b0;
            ed[d] = '0;
            ee[d] = 1'b0;
        end
        edges = 0;
    endtask

    // One clock cycle: called 1 time unit after a rising edge.
    task automatic cycle(input bit v, input bit we, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] st, input bit rr);
        bit acc;
        req_valid = v; req_we = we; address = a; wdata = wd; wstrb = st; rsp_ready = rr;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("req_ready[%0d] edge%0d", d, edges), 32'(req_ready_o[d]), 32'(model_ready(d)));
        end
        for (int d = 0; d < 2; d++) begin
            acc = v && model_ready(d);
            if (acc && we && int'(a) < depth[d]) begin
                for (int i = 0; i < 4; i++) begin
                    if (st[i]) mem[d][a][8*i +: 8] = wd[8*i +: 8];
                end
            end
            if (acc && !we) begin
                ev[d] = 1'b1;
                if (int'(a) < depth[d]) begin
                    ed[d] = mem[d][a];
                    ee[d] = 1'b0;
                end else begin
                    ed[d] = '0;
                    ee[d] = 1'b1;
                end
            end else if (ev[d] && rr) begin
                ev[d] = 1'b0;
            end
        end
        edges++;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rsp_valid[%0d]", d), 32'(rsp_valid_o[d]), 32'(ev[d]));
            chk($sformatf("init_done[%0d]", d), 32'(init_done_o[d]), 32'(edges >= depth[d]));
            if (ev[d]) begin
                chk($sformatf("outputf[%0d] addr%h", d, a), outputf_o[d], ed[d]);
                chk($sformatf("rsp_err[%0d]", d), 32'(rsp_err_o[d]), 32'(ee[d]));
            end
        end
        $display("cycle edge=%0d v=%0b we=%0b a=%h wd=%h st=%h rr=%0b | A: rv=%0b d=%h e=%0b | B: rv=%0b d=%h e=%0b",
                 edges, v, we, a, wd, st, rr, rsp_valid_o[0], outputf_o[0], rsp_err_o[0],
                 rsp_valid_o[1], outputf_o[1], rsp_err_o[1]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; address = '0;
        wdata = '0; wstrb = '0; rsp_ready = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", 32'(req_ready_o[d]), 32'd0);
            chk("reset rsp_valid", 32'(rsp_valid_o[d]), 32'd0);
            chk("reset outputf",   outputf_o[d],        32'd0);
            chk("reset rsp_err",   32'(rsp_err_o[d]),   32'd0);
            chk("reset init_done", 32'(init_done_o[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Clear sequence: ready timing is checked every cycle by the model.
        idle(256);
        chk("init_done after 256", 32'(init_done_o[0]), 32'd1);

        cycle(1'b1, 1'b0, 8'h10, 32'h0, 4'h0, 1'b1);
        chk("read 0x10 after clear", outputf_o[0], 32'h0000_0000);

        cycle(1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        cycle(1'b1, 1'b1, 8'h05, 32'h0000_00AA, 4'b0001, 1'b1);
        cycle(1'b1, 1'b0, 8'h05, 32'h0, 4'hF, 1'b1);
        chk("strobed merge 0x05", outputf_o[0], 32'hDEAD_BEAA);

        cycle(1'b1, 1'b1, 8'h01, 32'h1111_1111, 4'hF, 1'b1);
        cycle(1'b1, 1'b1, 8'h02, 32'h2222_2222, 4'hF, 1'b1);
        cycle(1'b1, 1'b1, 8'h03, 32'h3333_3333, 4'hF, 1'b1);
        cycle(1'b1, 1'b0, 8'h01, 32'h0, 4'h0, 1'b1);
        cycle(1'b1, 1'b0, 8'h02, 32'h0, 4'h0, 1'b1);
        chk("b2b second", outputf_o[0], 32'h2222_2222);
        cycle(1'b1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b1);
        chk("b2b third", outputf_o[0], 32'h3333_3333);
        idle(1);

        // Stall: response must hold while rsp_ready is low.
        cycle(1'b1, 1'b1, 8'h07, 32'h0707_0707, 4'hF, 1'b1);
        cycle(1'b1, 1'b0, 8'h07, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 8'h08, 32'h0, 4'h0, 1'b0);
        chk("stall hold 0x07", outputf_o[0], 32'h0707_0707);
        cycle(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1);

        // Out of range for the 200-word instance, in range for the 256-word one.
        cycle(1'b1, 1'b1, 8'hF0, 32'h0000_0055, 4'hF, 1'b1);
        cycle(1'b1, 1'b0, 8'hF0, 32'h0, 4'h0, 1'b1);
        chk("oor outputf B", outputf_o[1], 32'h0);
        chk("oor rsp_err B", 32'(rsp_err_o[1]), 32'd1);
        chk("in range 0xF0 A", outputf_o[0], 32'h0000_0055);
        cycle(1'b1, 1'b0, 8'h28, 32'h0, 4'h0, 1'b1);
        chk("no alias 0x28 B", outputf_o[1], 32'h0);
        idle(1);

        // Asynchronous reset with a response pending.
        cycle(1'b1, 1'b1, 8'h03, 32'h1234_5678, 4'hF, 1'b1);
        cycle(1'b1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async drop rsp_valid", 32'(rsp_valid_o[d]), 32'd0);
            chk("async req_ready",      32'(req_ready_o[d]), 32'd0);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(256);
        cycle(1'b1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b1);
        chk("re-cleared 0x03", outputf_o[0], 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
